// File: rtl/icache_plru_ways.sv
// icache_plru_ways: tag match, per-set valid tracking and tree-PLRU victim selection
module icache_plru_ways #(
  parameter int WAYS = 4,
  parameter int TAG_W = 20,
  parameter int LINE_W = 128,
  parameter int SET_W = 4,
  localparam int WW = $clog2(WAYS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic [1:0]              op_code,
  input  logic [SET_W-1:0]        op_set,
  input  logic [TAG_W-1:0]        op_tag,
  input  logic [WAYS*TAG_W-1:0]   way_tags,
  input  logic [WAYS*LINE_W-1:0]  way_lines,
  output logic                    res_valid,
  output logic                    res_hit,
  output logic [WW-1:0]           res_way,
  output logic [LINE_W-1:0]       res_line
);
  localparam int NS = 1 << SET_W;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t state, state_d;
  logic [SET_W-1:0] sweep_cnt;
  logic [WAYS-1:0] valid [NS];
  logic [WAYS-2:0] plru [NS];
  logic [WAYS-1:0] cur_valid;
  logic [WAYS-2:0] cur_plru;
  logic hit, accept;
  logic [WW-1:0] hit_way, victim;

  function automatic logic [WAYS-2:0] touch(input logic [WAYS-2:0] p, input logic [WW-1:0] w);
    int n = 0;
    touch = p;
    for (int l = WW - 1; l >= 0; l--) begin
      touch[n] = ~w[l];
      n = 2 * n + 1 + int'(w[l]);
    end
  endfunction

  function automatic logic [WW-1:0] leaf(input logic [WAYS-2:0] p);
    int n = 0;
    leaf = '0;
    for (int l = WW - 1; l >= 0; l--) begin
      leaf[l] = p[n];
      n = 2 * n + 1 + int'(p[n]);
    end
  endfunction

  assign cur_valid = valid[op_set];
  assign cur_plru = plru[op_set];
  assign op_ready = state == IDLE;
  assign accept = op_valid && op_ready;

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = leaf(cur_plru);
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (cur_valid[w] && way_tags[w*TAG_W +: TAG_W] == op_tag) begin
        hit = 1'b1;
        hit_way = WW'(w);
      end
      if (!cur_valid[w]) victim = WW'(w);
    end
  end

  always_comb state_d = state == IDLE ? (accept && op_code == 2'd3 ? SWEEP : IDLE)
                                      : (&sweep_cnt ? IDLE : SWEEP);

  always_ff @(posedge clk) state <= rst ? IDLE : state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt <= '0;
      res_valid <= 1'b0;
      res_hit <= 1'b0;
      res_way <= '0;
      res_line <= '0;
      for (int s = 0; s < NS; s++) begin
        valid[s] <= '0;
        plru[s] <= '0;
      end
    end else begin
      res_valid <= 1'b0;
      res_hit <= 1'b0;
      res_way <= '0;
      res_line <= '0;
      if (state == SWEEP) begin
        valid[sweep_cnt] <= '0;
        plru[sweep_cnt] <= '0;
        sweep_cnt <= sweep_cnt + 1'b1;
        res_valid <= &sweep_cnt;
      end else if (accept && op_code != 2'd3) begin
        res_valid <= 1'b1;
        if (op_code == 2'd1) begin
          valid[op_set][victim] <= 1'b1;
          plru[op_set] <= touch(cur_plru, victim);
          res_way <= victim;
        end else if (hit) begin
          res_hit <= 1'b1;
          res_way <= hit_way;
          res_line <= way_lines[hit_way*LINE_W +: LINE_W];
          plru[op_set] <= touch(cur_plru, hit_way);
          if (op_code == 2'd2) valid[op_set][hit_way] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_plru_ways.sv
// tb_icache_plru_ways: WAYS=4/2/8 instances checked every cycle against a range-walk PLRU model
module tb_icache_plru_ways;
  bit clk = 0;
  logic rst = 1, op_valid = 0;
  logic [1:0] op_code = 0;
  logic [3:0] op_set = 0;
  logic [19:0] op_tag = 0;
  int total = 0, bad = 0, post_n = 0, post_seen = 0;
  bit chk_en = 0;
  string post_name;
  logic [159:0] post_act, post_want;

  always #5 clk = ~clk;

  function automatic logic [127:0] mk_line(logic [19:0] t, logic [3:0] s, logic [3:0] w);
    return {4{t, s, w, 4'h5}};
  endfunction

  function automatic logic [159:0] pk(logic rdy, logic v, logic h, logic [3:0] w, logic [127:0] line);
    return {25'd0, rdy, v, h, w, line};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int W = g == 0 ? 4 : g == 1 ? 2 : 8;
    localparam int WW = $clog2(W);
    logic [W*20-1:0] wt;
    logic [W*128-1:0] wl;
    logic rdy, r_valid, r_hit;
    logic [WW-1:0] r_way;
    logic [127:0] r_line;
    logic [19:0] tram [16][W];
    bit mv [16][W];
    bit mp [16][W];
    bit busy, e_valid, e_hit, e_wchk;
    int cnt, e_way;
    logic [127:0] e_line;
    logic [159:0] act, want;

    icache_plru_ways #(.WAYS(W)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(rdy), .op_code(op_code),
      .op_set(op_set), .op_tag(op_tag), .way_tags(wt), .way_lines(wl),
      .res_valid(r_valid), .res_hit(r_hit), .res_way(r_way), .res_line(r_line)
    );

    always_comb begin
      wt = '0;
      wl = '0;
      for (int w = 0; w < W; w++) begin
        wt[w*20 +: 20] = tram[op_set][w];
        wl[w*128 +: 128] = mk_line(tram[op_set][w], op_set, 4'(w));
      end
    end

    assign act = pk(rdy, r_valid, e_valid & r_hit, e_valid & e_wchk ? 4'(r_way) : 4'd0,
                    e_valid ? r_line : 128'd0);
    assign want = pk(!busy, e_valid, e_hit, e_wchk ? 4'(e_way) : 4'd0, e_line);

    function automatic int victim(int s);
      int lo = 0, hi = W, n = 0, mid;
      for (int w = 0; w < W; w++) if (!mv[s][w]) return w;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (mp[s][n]) begin lo = mid; n = 2 * n + 2; end
        else begin hi = mid; n = 2 * n + 1; end
      end
      return lo;
    endfunction

    function automatic void touch(int s, int w);
      int lo = 0, hi = W, n = 0, mid;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (w < mid) begin mp[s][n] = 1; n = 2 * n + 1; hi = mid; end
        else begin mp[s][n] = 0; n = 2 * n + 2; lo = mid; end
      end
    endfunction

    always @(posedge clk) begin
      automatic int s = int'(op_set), hw = 0, v;
      automatic bit h = 0;
      e_valid = 0; e_hit = 0; e_wchk = 0; e_way = 0; e_line = '0;
      if (rst) begin
        busy = 0; cnt = 0;
        for (int i = 0; i < 16; i++)
          for (int w = 0; w < W; w++) begin
            mv[i][w] = 0; mp[i][w] = 0; tram[i][w] <= '0;
          end
      end else if (busy) begin
        for (int w = 0; w < W; w++) begin mv[cnt][w] = 0; mp[cnt][w] = 0; end
        cnt++;
        if (cnt == 16) begin busy = 0; cnt = 0; e_valid = 1; e_wchk = 1; end
      end else if (op_valid) begin
        for (int w = W - 1; w >= 0; w--)
          if (mv[s][w] && tram[s][w] == op_tag) begin h = 1; hw = w; end
        if (op_code == 3) begin
          busy = 1; cnt = 0;
        end else begin
          e_valid = 1;
          if (op_code == 1) begin
            v = victim(s);
            mv[s][v] = 1; touch(s, v); tram[s][v] <= op_tag;
            e_wchk = 1; e_way = v;
          end else if (h) begin
            e_hit = 1; e_wchk = 1; e_way = hw;
            e_line = mk_line(op_tag, 4'(s), 4'(hw));
            touch(s, hw);
            if (op_code == 2) mv[s][hw] = 0;
          end
        end
      end
    end
  end

  task automatic check(string name, logic [159:0] act, logic [159:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s act=%h want=%h", name, act, want);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("w4", cfg[0].act, cfg[0].want);
    check("w2", cfg[1].act, cfg[1].want);
    check("w8", cfg[2].act, cfg[2].want);
    if (post_n != post_seen) begin
      check(post_name, post_act, post_want);
      post_seen = post_n;
    end
  end

  task automatic op(logic [1:0] c, logic [3:0] s, logic [19:0] t);
    op_valid = 1; op_code = c; op_set = s; op_tag = t;
    @(posedge clk); #1;
    op_valid = 0;
  endtask

  task automatic post(string name, logic [159:0] act, logic [159:0] want);
    post_name = name; post_act = act; post_want = want; post_n++;
    @(negedge clk); #1;
  endtask

  initial begin
    int n_low, n_strobe, r;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 0;
    post("reset_state", cfg[0].act, pk(1, 0, 0, 0, 0));
    op(0, 3, 20'h12345);
    post("lookup_cold", cfg[0].act, pk(1, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      op(1, 5, 20'hA0000 + 20'(i));
      post("fill_order", cfg[0].act, pk(1, 1, 0, 4'(i), 0));
    end
    op(1, 5, 20'hA0004);
    post("fill_fifth", cfg[0].act, pk(1, 1, 0, 0, 0));
    op(0, 5, 20'hA0004);
    post("hit_way0", cfg[0].act, pk(1, 1, 1, 0, mk_line(20'hA0004, 5, 0)));
    op(1, 5, 20'hA0005);
    post("fill_after_hit", cfg[0].act, pk(1, 1, 0, 2, 0));
    op(1, 9, 20'hB0000);
    op(1, 9, 20'hB0001);
    op(2, 9, 20'hB0001);
    post("inval_hit", cfg[0].act, pk(1, 1, 1, 1, mk_line(20'hB0001, 9, 1)));
    op(0, 9, 20'hB0001);
    post("lookup_after_inval", cfg[0].act, pk(1, 1, 0, 0, 0));
    op(1, 2, 20'hC0000);
    op(1, 2, 20'hC0000);
    op(0, 2, 20'hC0000);
    post("dup_lowest", cfg[0].act, pk(1, 1, 1, 0, mk_line(20'hC0000, 2, 0)));
    op(3, 0, 0);
    n_low = 0; n_strobe = 0;
    repeat (24) begin
      if (!cfg[0].rdy) n_low++;
      if (cfg[0].r_valid) n_strobe++;
      op_valid = !cfg[0].rdy; op_code = 1; op_set = 5; op_tag = 20'hD0000;
      @(posedge clk); #1;
    end
    op_valid = 0;
    post("sweep_len", 160'({n_low, n_strobe}), 160'({32'd16, 32'd1}));
    op(0, 5, 20'hA0004);
    post("lookup_after_sweep", cfg[0].act, pk(1, 1, 0, 0, 0));
    op(3, 0, 0);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    post("rst_mid_sweep_rdy", cfg[0].act, pk(1, 0, 0, 0, 0));
    n_strobe = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (cfg[0].r_valid) n_strobe++;
    end
    post("rst_mid_sweep_strobe", 160'(n_strobe), 160'd0);
    repeat (600) begin
      r = int'($urandom_range(0, 99));
      op_valid = $urandom_range(0, 9) < 8;
      op_code = r < 45 ? 2'd0 : r < 80 ? 2'd1 : r < 98 ? 2'd2 : 2'd3;
      op_set = 4'($urandom_range(0, 3));
      op_tag = 20'h100 + 20'($urandom_range(0, 5));
      @(posedge clk); #1;
    end
    op_valid = 0;
    repeat (20) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
